// File: rtl/fpu_instr_encoder_if.sv
// fpu_instr_encoder_if: request, issue and completion channels of the FPU instruction encoder
interface fpu_instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fused;
  logic [4:0]  req_funct;
  logic [2:0]  req_rm;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rs3;
  logic [2:0]  frm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        resp_done;
  modport master (
    output req_valid, req_fused, req_funct, req_rm, req_rd, req_rs1, req_rs2, req_rs3, frm,
    output instr_ready, resp_done,
    input  req_ready, instr_valid, instr
  );
  modport slave (
    input  req_valid, req_fused, req_funct, req_rm, req_rd, req_rs1, req_rs2, req_rs3, frm,
    input  instr_ready, resp_done,
    output req_ready, instr_valid, instr
  );
endinterface

// File: rtl/fpu_instr_encoder.sv
// fpu_instr_encoder: encodes Zhinx requests into OP-FP/R4 words, queues and issues them under a credit limit (optional FPU_DYN_RESOLVE_EN resolves RM_DYN from frm)
module fpu_instr_encoder #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  fpu_instr_encoder_if.slave       s,
  output logic                     err_illegal,
  output logic                     err_underflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [$clog2(MAX_OUT):0] outstanding
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam logic [4:0] FUNCT_ADD    = 5'b00000;
  localparam logic [4:0] FUNCT_SUB    = 5'b00001;
  localparam logic [4:0] FUNCT_MUL    = 5'b00010;
  localparam logic [4:0] FUNCT_DIV    = 5'b00011;
  localparam logic [4:0] FUNCT_SGNJ   = 5'b00100;
  localparam logic [4:0] FUNCT_MINMAX = 5'b00101;
  localparam logic [4:0] FUNCT_SQRT   = 5'b01011;
  localparam logic [4:0] FUNCT_COMP   = 5'b10100;
  localparam logic [4:0] FUNCT_CLASS  = 5'b11100;
  localparam logic [1:0] FMT_HALF     = 2'b10;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fused, arith, known, rm_bad, dyn_bad, legal, accept, push, fire;
  logic [2:0]    rm_res, rm_eff;
  logic [4:0]    rs2_eff;
  logic [6:0]    opcode;
  logic [31:0]   word;

  assign fused = s.req_fused != 2'b00;
  assign arith = fused || s.req_funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_DIV, FUNCT_SQRT};

`ifdef FPU_DYN_RESOLVE_EN
  assign rm_res  = (arith && s.req_rm == 3'b111) ? s.frm : s.req_rm;
  assign dyn_bad = arith && s.req_rm == 3'b111 && s.frm inside {3'b101, 3'b110, 3'b111};
`else
  logic unused_frm;
  assign unused_frm = ^s.frm;
  assign rm_res  = s.req_rm;
  assign dyn_bad = 1'b0;
`endif

  // Legality check and field assembly of the encoded word
  always_comb begin
    known   = arith || s.req_funct inside {FUNCT_SGNJ, FUNCT_MINMAX, FUNCT_COMP, FUNCT_CLASS};
    rm_bad  = arith ? s.req_rm inside {3'b101, 3'b110} :
              s.req_funct == FUNCT_MINMAX ? s.req_rm > 3'b001 :
              s.req_funct inside {FUNCT_COMP, FUNCT_SGNJ} ? s.req_rm > 3'b010 : 1'b0;
    legal   = known && !rm_bad && !dyn_bad;
    rm_eff  = (!fused && s.req_funct == FUNCT_CLASS) ? 3'b001 : rm_res;
    rs2_eff = (!fused && s.req_funct inside {FUNCT_SQRT, FUNCT_CLASS}) ? 5'd0 : s.req_rs2;
    opcode  = !fused ? 7'b1010011 :
              s.req_fused == 2'b01 ? 7'b1000011 :
              s.req_fused == 2'b10 ? 7'b1000111 :
              s.req_funct[0] ? 7'b1001011 : 7'b1001111;
    word    = {fused ? s.req_rs3 : s.req_funct, FMT_HALF, rs2_eff, s.req_rs1, rm_eff, s.req_rd, opcode};
  end

  assign s.req_ready   = fifo_count != CW'(DEPTH);
  assign accept        = s.req_valid && s.req_ready;
  assign push          = accept && legal;
  assign s.instr_valid = fifo_count != '0 && outstanding < OW'(MAX_OUT);
  assign fire          = s.instr_valid && s.instr_ready;
  assign s.instr       = fifo_count != '0 ? mem[rd_ptr] : '0;

  // Word storage; entries are only visible while occupancy covers them, so no reset
  always_ff @(posedge CLK) if (push) mem[wr_ptr] <= word;

  // Pointers, occupancy, issue credits and error flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      outstanding   <= '0;
      err_illegal   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      fifo_count  <= fifo_count + CW'(push) - CW'(fire);
      outstanding <= outstanding + OW'(fire) - OW'(s.resp_done && (fire || outstanding != '0));
      err_illegal <= accept && !legal;
      if (s.resp_done && !fire && outstanding == '0) err_underflow <= 1'b1;
    end
  end
endmodule
